snes_pad_reader: RTL and testbench

//  Host-side initiator for a physical SNES controller port: generates LATCH/CLOCK, shifts in 16 serial bits.

---
 rtl/snes_pad_reader.sv | 237 +++++++++++++++++++++++
 tb/tb_snes_pad_reader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/snes_pad_reader.sv
// snes_pad_reader
//   Host-side SNES controller scanner. Generates LATCH/CLOCK toward the pad,
//   shifts in 16 serial bits and publishes them active-low in native pad order.
//   Optional build macro: SNES_PAD_MATCH_EN -- publish only after two
//   consecutive identical scans (debounce against contact bounce / noise).
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | latch low, clock high, waiting for a pending poll request
//   LATCH | latch high for 2*HALF_CYC cycles, pad captures its buttons
//   HIGH  | clock high for HALF_CYC cycles, data sampled on last cycle
//   LOW   | clock low for HALF_CYC cycles, pad shifts on the next rise
//   DONE  | single cycle, result handed to the publish register

module snes_pad_reader #(
   parameter int CLK_HZ  = 21477300,
   parameter int POLL_HZ = 60
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        pad_data,
   output logic        pad_latch,
   output logic        pad_clk,
   output logic [15:0] buttons,
   output logic        valid,
   output logic        busy
);

   localparam int HALF_CYC = (CLK_HZ / 1000) * 6 / 1000;
   localparam int POLL_CYC = CLK_HZ / POLL_HZ;
   localparam int TMR_W    = $clog2(2 * HALF_CYC);
   localparam int POLL_W   = $clog2(POLL_CYC);

   localparam logic [TMR_W-1:0]  LATCH_LOAD = TMR_W'(2 * HALF_CYC - 1);
   localparam logic [TMR_W-1:0]  HALF_LOAD  = TMR_W'(HALF_CYC - 1);
   localparam logic [TMR_W-1:0]  TMR_ONE    = TMR_W'(1);
   localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_CYC - 1);
   localparam logic [POLL_W-1:0] POLL_ONE   = POLL_W'(1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LATCH = 3'd1,
      S_HIGH  = 3'd2,
      S_LOW   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t              state, state_nxt;
   logic [TMR_W-1:0]    tmr, tmr_nxt;
   logic [3:0]          bit_idx, bit_nxt;
   logic [15:0]         shreg;
   logic [POLL_W-1:0]   poll_cnt;
   logic                pending;
   logic                poll_wrap;
   logic                take_pending;
   logic                shift_en;
   logic                publish;
   logic                latch_nxt;
   logic                clk_nxt;
   logic                busy_nxt;
   logic                data_meta;
   logic                data_sync;

   assign poll_wrap = enable && (poll_cnt == POLL_LAST);

   // Bring the asynchronous pad data into the clk domain.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_meta <= 1'b1;
         data_sync <= 1'b1;
      end else begin
         data_meta <= pad_data;
         data_sync <= data_meta;
      end
   end

   // Free-running poll interval; parked at zero whenever scanning is disabled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         poll_cnt <= '0;
      end else if (!enable) begin
         poll_cnt <= '0;
      end else if (poll_wrap) begin
         poll_cnt <= '0;
      end else begin
         poll_cnt <= poll_cnt + POLL_ONE;
      end
   end

   // Scan request flag; wraps during a scan collapse into one request, a
   // fresh wrap wins over the consume so no interval is ever lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending <= 1'b0;
      end else if (!enable) begin
         pending <= 1'b0;
      end else if (poll_wrap) begin
         pending <= 1'b1;
      end else if (take_pending) begin
         pending <= 1'b0;
      end
   end

   // FSM state, phase timer and bit index registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         tmr     <= '0;
         bit_idx <= '0;
      end else begin
         state   <= state_nxt;
         tmr     <= tmr_nxt;
         bit_idx <= bit_nxt;
      end
   end

   // Next-state logic; pad-facing outputs are decoded from the next state so
   // they come straight out of flops and cannot glitch.
   always_comb begin
      state_nxt    = state;
      tmr_nxt      = tmr;
      bit_nxt      = bit_idx;
      take_pending = 1'b0;
      shift_en     = 1'b0;
      publish      = 1'b0;
      case (state)
         S_IDLE: begin
            if (pending) begin
               state_nxt    = S_LATCH;
               tmr_nxt      = LATCH_LOAD;
               take_pending = 1'b1;
            end
         end
         S_LATCH: begin
            if (tmr == '0) begin
               state_nxt = S_HIGH;
               tmr_nxt   = HALF_LOAD;
               bit_nxt   = 4'd0;
            end else begin
               tmr_nxt = tmr - TMR_ONE;
            end
         end
         S_HIGH: begin
            if (tmr == '0) begin
               shift_en  = 1'b1;
               state_nxt = S_LOW;
               tmr_nxt   = HALF_LOAD;
            end else begin
               tmr_nxt = tmr - TMR_ONE;
            end
         end
         S_LOW: begin
            if (tmr == '0) begin
               if (bit_idx == 4'd15) begin
                  state_nxt = S_DONE;
               end else begin
                  state_nxt = S_HIGH;
                  tmr_nxt   = HALF_LOAD;
                  bit_nxt   = bit_idx + 4'd1;
               end
            end else begin
               tmr_nxt = tmr - TMR_ONE;
            end
         end
         S_DONE: begin
            publish   = 1'b1;
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
      latch_nxt = (state_nxt == S_LATCH);
      clk_nxt   = (state_nxt != S_LOW);
      busy_nxt  = (state_nxt != S_IDLE);
   end

   // Registered pad-facing strobes and scan-in-progress flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pad_latch <= 1'b0;
         pad_clk   <= 1'b1;
         busy      <= 1'b0;
      end else begin
         pad_latch <= latch_nxt;
         pad_clk   <= clk_nxt;
         busy      <= busy_nxt;
      end
   end

   // First bit out of the pad ends up in bit 0 after sixteen shifts.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shreg <= '1;
      end else if (shift_en) begin
         shreg <= {data_sync, shreg[15:1]};
      end
   end

`ifdef SNES_PAD_MATCH_EN
   logic [15:0] prev;

   // Publish only when two back-to-back scans agree.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev    <= '1;
         buttons <= '1;
         valid   <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (publish) begin
            prev <= shreg;
            if (shreg == prev) begin
               buttons <= shreg;
               valid   <= 1'b1;
            end
         end
      end
   end
`else
   // Every completed scan is published with a one-cycle valid strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         buttons <= '1;
         valid   <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (publish) begin
            buttons <= shreg;
            valid   <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_snes_pad_reader.sv
// tb_snes_pad_reader
//   Drives snes_pad_reader with a behavioural SNES pad and checks timing and
//   published words. Expected words are queued when a scan latches the pad
//   and popped when valid pulses. Honour SNES_PAD_MATCH_EN the same as the RTL.

module tb_snes_pad_reader;

   localparam int HALF = 6;

   logic        clk    = 1'b0;
   logic        reset  = 1'b0;
   logic        enable = 1'b0;
   logic        pad_data = 1'b1;
   logic        pad_latch;
   logic        pad_clk;
   logic [15:0] buttons;
   logic        valid;
   logic        busy;

   snes_pad_reader #(
      .CLK_HZ (1000000),
      .POLL_HZ(1000)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .pad_data (pad_data),
      .pad_latch(pad_latch),
      .pad_clk  (pad_clk),
      .buttons  (buttons),
      .valid    (valid),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Scoreboard and pad model
   logic [15:0] exp_q[$];
   logic [15:0] pad_word = 16'hFFFF;
   logic [15:0] pad_sr   = 16'hFFFF;
   logic [15:0] tb_prev  = 16'hFFFF;

   initial forever begin
      @(posedge pad_latch or posedge pad_clk);
      if (pad_latch) begin
         pad_sr   = pad_word;
         pad_data = pad_sr[0];
`ifdef SNES_PAD_MATCH_EN
         if (pad_word == tb_prev) exp_q.push_back(pad_word);
         tb_prev = pad_word;
`else
         exp_q.push_back(pad_word);
`endif
      end else begin
         pad_sr   = {1'b1, pad_sr[15:1]};
         pad_data = pad_sr[0];
      end
   end

   // Timing monitor
   logic lat_q = 1'b0, pclk_q = 1'b1, busy_q = 1'b0, valid_q = 1'b0;
   int lat_run = 0, lat_len = 0, low_run = 0, low_bad = 0, falls = 0;
   int busy_run = 0, busy_len = 0, busy_done = 0;
   int rise_cnt = 0, last_rise = 0, rise_gap = 0, valid_cnt = 0, valid_run = 0;

   always @(negedge clk) begin
      if (pad_latch && !lat_q) begin
         lat_run  = 1;
         rise_cnt++;
         rise_gap  = cyc - last_rise;
         last_rise = cyc;
         falls     = 0;
         low_bad   = 0;
      end else if (pad_latch) begin
         lat_run++;
      end else if (lat_q) begin
         lat_len = lat_run;
      end

      if (!pad_clk && pclk_q) begin
         falls++;
         low_run = 1;
      end else if (!pad_clk) begin
         low_run++;
      end else if (!pclk_q) begin
         if (low_run != HALF) low_bad++;
      end

      if (busy && !busy_q) busy_run = 1;
      else if (busy) busy_run++;
      else if (busy_q) begin
         busy_len = busy_run;
         busy_done++;
      end

      if (valid) begin
         if (!valid_q) valid_run = 1;
         else valid_run++;
         if (!valid_q) begin
            valid_cnt++;
            if (exp_q.size() == 0) chk("sb_unexpected_valid", {16'h0, buttons}, 32'hFFFF_FFFF);
            else chk("sb_buttons", {16'h0, buttons}, {16'h0, exp_q.pop_front()});
         end
      end else if (valid_q) begin
         chk("valid_width", valid_run, 1);
      end

      lat_q   = pad_latch;
      pclk_q  = pad_clk;
      busy_q  = busy;
      valid_q = valid;
   end

   task automatic wait_valid(input int budget, input string tag);
      int v0 = valid_cnt;
      int n  = 0;
      while (valid_cnt == v0 && n < budget) begin
         @(negedge clk); #1; n++;
      end
      chk(tag, valid_cnt - v0, 1);
   endtask

   task automatic wait_falls(input int target, input int budget, input string tag);
      int r0 = rise_cnt;
      int n  = 0;
      while (!(rise_cnt > r0 && falls >= target) && n < budget) begin
         @(negedge clk); #1; n++;
      end
      chk(tag, falls, target);
   endtask

   task automatic wait_scan(input int budget, input string tag);
      int b0 = busy_done;
      int n  = 0;
      while (busy_done == b0 && n < budget) begin
         @(negedge clk); #1; n++;
      end
      chk(tag, busy_done - b0, 1);
   endtask

   task automatic chk_scan_shape(input string tag);
      chk({tag, "_latch_len"}, lat_len, 2 * HALF);
      chk({tag, "_falls"}, falls, 16);
      chk({tag, "_low_bad"}, low_bad, 0);
      chk({tag, "_busy_len"}, busy_len, 205);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0;
      logic [15:0] pats [4];
      pats[0] = 16'hF0A5;
      pats[1] = 16'h1234;
      pats[2] = 16'h0000;
      pats[3] = 16'hFFFE;

      #1 reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      chk("rst_buttons", {16'h0, buttons}, 32'hFFFF);
      chk("rst_latch", pad_latch, 0);
      chk("rst_pclk", pad_clk, 1);
      chk("rst_valid", valid, 0);
      chk("rst_busy", busy, 0);
      reset = 1'b0;

`ifndef SNES_PAD_MATCH_EN
      for (int i = 0; i < 4; i++) begin
         pad_word = pats[i];
         enable   = 1'b1;
         wait_valid(1500, "scan_valid");
         chk_scan_shape("scan");
         chk("scan_buttons", {16'h0, buttons}, {16'h0, pats[i]});
         if (i > 0) chk("latch_period", rise_gap, 1000);
      end

      pad_word = 16'h5A3C;
      wait_falls(8, 1500, "drop_at_bit7");
      enable = 1'b0;
      wait_valid(300, "drop_valid");
      chk("drop_falls", falls, 16);
      chk("drop_buttons", {16'h0, buttons}, 32'h5A3C);
      r0 = rise_cnt;
      repeat (2500) @(negedge clk);
      #1;
      chk("drop_no_rescan", rise_cnt - r0, 0);
      chk("drop_busy", busy, 0);

      pad_word = 16'h0F0F;
      enable   = 1'b1;
      wait_falls(10, 1500, "rst_at_bit9");
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      chk("midrst_pclk", pad_clk, 1);
      chk("midrst_latch", pad_latch, 0);
      chk("midrst_buttons", {16'h0, buttons}, 32'hFFFF);
      chk("midrst_busy", busy, 0);
      exp_q.delete();
      tb_prev = 16'hFFFF;
      repeat (3) @(negedge clk);
      reset    = 1'b0;
      pad_word = 16'hA5F0;
      wait_valid(1500, "post_rst_valid");
      chk_scan_shape("post_rst");
`else
      enable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         pad_word = (i % 2 == 0) ? 16'hF0A5 : 16'hF0A4;
         wait_scan(1500, "alt_scan");
      end
      chk("alt_valid_cnt", valid_cnt, 0);
      chk("alt_buttons", {16'h0, buttons}, 32'hFFFF);

      pad_word = 16'hF0A5;
      wait_scan(1500, "same_scan1");
      chk("same1_buttons", {16'h0, buttons}, 32'hFFFF);
      wait_scan(1500, "same_scan2");
      repeat (2) @(negedge clk);
      #1;
      chk_scan_shape("same2");
      chk("same2_buttons", {16'h0, buttons}, 32'hF0A5);
      chk("same2_valid_cnt", valid_cnt, 1);
`endif

      chk("sb_drain", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
